// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor and its slice.
package nibble_serial_adder_pkg;

  // Width of one ripple-carry slice; every operation walks the operands in
  // steps of this many bits, LSB nibble first.
  localparam int NIBBLE_W = 4;

  // Controller states. IDLE accepts operands, RUN feeds one nibble per
  // cycle through the slice, DONE presents the result until it is taken.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// 4-bit ripple-carry slice: sum = a + b + cin, with the carry out of bit 3.
module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling from bit 0 to bit 3.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit slice.
// Operands are captured once, then one nibble per cycle passes through the
// slice with the carry held in a register between cycles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid (and its payload) until the transfer;
// ready is decoded from state only and never depends on the partner's valid.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  // Reject widths that cannot be cut into whole nibbles.
  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] b_eff;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] sum_next;
  logic             last;

  // Subtraction is A + ~B + 1: invert B here, the +1 enters as initial carry.
  assign b_eff = op_sub ? ~b : b;

  add4 u_add4 (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result nibbles enter at the MSB end so that after NIB shifts the first
  // (least significant) nibble has arrived at bits [3:0].
  assign slice_ext = WIDTH'(slice_sum);
  assign sum_next  = (sum_reg >> NIBBLE_W) | (slice_ext << (WIDTH - NIBBLE_W));
  assign last      = (cnt == CNT_W'(NIB - 1));

  // Ready/valid come from state alone; reset forces in_ready low.
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);

  // Controller, operand shifters, carry register and registered outputs.
  // The output registers load only on the final nibble, so an aborted
  // operation never exposes a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= op_sub;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_reg   <= a_reg >> NIBBLE_W;
          b_reg   <= b_reg >> NIBBLE_W;
          sum_reg <= sum_next;
          carry   <= slice_cout;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state <= ST_DONE;
            sum   <= sum_next;
            cout  <= slice_cout;
            // Signed overflow: like-signed inputs giving an unlike-signed sum.
            ovf   <= (a_msb == b_msb) && (slice_sum[3] != a_msb);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 32-bit instance for the main
// arithmetic, handshake, backpressure and reset cases, and a 4-bit instance
// for the single-nibble boundary and back-to-back throughput.
module tb_nibble_serial_adder;

  localparam int W  = 32;
  localparam int W4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          op_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- 4-bit instance ----------------
  logic          in_valid4 = 1'b0;
  logic          in_ready4;
  logic [W4-1:0] a4 = '0;
  logic [W4-1:0] b4 = '0;
  logic          op_sub4 = 1'b0;
  logic          out_valid4;
  logic          out_ready4 = 1'b0;
  logic [W4-1:0] sum4;
  logic          cout4;
  logic          ovf4;

  nibble_serial_adder #(.WIDTH(W4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .op_sub    (op_sub4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .ovf       (ovf4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_ready32(input string tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
  endtask

  // Present one operand set, then count cycles until out_valid.
  task automatic start32(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sub, input logic [W-1:0] exp_sum);
    int lat;
    wait_ready32(tag);
    a = av; b = bv; op_sub = sub; in_valid = 1'b1;
    exp_q.push_back(exp_sum);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 9);
  endtask

  task automatic result32(input string tag, input logic exp_cout, input logic exp_ovf);
    logic [W-1:0] es;
    es = exp_q.pop_front();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  task automatic release32(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv, input logic sub,
                     input logic [3:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    check({tag, "_ready"}, in_ready4, 1);
    a4 = av; b4 = bv; op_sub4 = sub; in_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_sum"}, sum4, exp_sum);
    check({tag, "_cout"}, cout4, exp_cout);
    check({tag, "_ovf"}, ovf4, exp_ovf);
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc[$];
    int pre_lat;
    logic seen;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready4", in_ready4, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Add: 1 + FFFFFFFF wraps to 0 with carry out
    start32("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000);
    result32("add_wrap", 1'b1, 1'b0);
    release32("add_wrap");

    // Add: most positive + 1 overflows
    start32("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000);
    result32("add_ovf", 1'b0, 1'b1);
    release32("add_ovf");

    // Sub: 5 - 7 borrows
    start32("sub_neg", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE);
    result32("sub_neg", 1'b0, 1'b0);
    release32("sub_neg");

    // Sub: most negative - 1 overflows, no borrow
    start32("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF);
    result32("sub_ovf", 1'b1, 1'b1);
    release32("sub_ovf");

    // Backpressure: hold result for 5 cycles while inputs churn
    start32("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = $urandom;
      b = $urandom;
      op_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_sum", sum, exp_q[0]);
      check("bp_hold_cout", cout, 0);
      check("bp_hold_ovf", ovf, 0);
    end
    in_valid = 1'b0;
    result32("bp", 1'b0, 1'b0);
    release32("bp");

    // Next op after backpressure: 0x10 - 0x10
    start32("bp_next", 32'h10, 32'h10, 1'b1, 32'h0);
    result32("bp_next", 1'b1, 1'b0);
    release32("bp_next");

    // Reset during RUN cycle 4 aborts the operation
    wait_ready32("abort");
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pre_lat = 1;
    while (pre_lat < 4) begin
      @(negedge clk);
      pre_lat++;
    end
    check("abort_running", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready_rst", in_ready, 0);
    check("abort_sum_clear", sum, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_valid", seen, 0);

    start32("after_abort", 32'd3, 32'd4, 1'b0, 32'd7);
    result32("after_abort", 1'b0, 1'b0);
    release32("after_abort");

    // WIDTH=4 instance: single-nibble operations
    op4("w4_add", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    op4("w4_sub", 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1);

    // WIDTH=4 back-to-back with in_valid held: one accept every 3 cycles
    a4 = 4'd3; b4 = 4'd2; op_sub4 = 1'b0;
    in_valid4 = 1'b1;
    out_ready4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready4) acc.push_back(i);
      if (out_valid4) check("w4_b2b_sum", sum4, 4'd5);
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    check("w4_b2b_count", acc.size(), 4);
    if (acc.size() >= 3) begin
      check("w4_b2b_gap1", acc[1] - acc[0], 3);
      check("w4_b2b_gap2", acc[2] - acc[1], 3);
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    out_ready4 = 1'b0;
    check("w4_b2b_idle", in_ready4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
